// File: rtl/ysyx_22040931_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   if_state_e   : fetch FSM state encoding (request / wait / hold)
//   RESET_PC_DEF : default PC loaded by reset
//   NOP_INST     : canonical nop (addi x0, x0, 0) used for marker slots
package ysyx_22040931_ifu_pkg;

    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic [1:0] {
        IfReq  = 2'b00,
        IfWait = 2'b01,
        IfHold = 2'b10
    } if_state_e;

endpackage

// File: rtl/ysyx_22040931_pc_reg.sv
// Program counter register for the fetch unit.
//   clk, rst   : core clock, synchronous active-high reset (loads RESET_PC)
//   load_i     : redirect request; wins over increment
//   load_pc_i  : redirect target
//   inc_i      : advance PC by 4 (wraps modulo 2^XLEN)
//   pc_o       : current PC
// Optional: YSYX_22040931_IFU_MISALIGN_EN keeps a misaligned target as-is so the
// fetch unit can report it; otherwise the target is forced to word alignment.
module ysyx_22040931_pc_reg #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    input  logic            inc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target;

`ifdef YSYX_22040931_IFU_MISALIGN_EN
    assign target = load_pc_i;
`else
    logic unused_lsb;
    assign unused_lsb = ^load_pc_i[1:0];
    assign target     = {load_pc_i[XLEN-1:2], 2'b00};
`endif

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target;
        end else if (inc_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_22040931_ifu.sv
// Instruction fetch stage: owns the PC, issues one fetch at a time to
// instruction memory and presents {pc, inst, opcode} to decode.
//   clk, rst                      : core clock, synchronous active-high reset
//   imem_req_valid/ready/addr     : fetch request (addr is the current PC)
//   imem_rsp_valid/data           : fetch response
//   redirect_valid/pc             : PC redirect from execute; kills unaccepted fetches
//   id_valid/ready/pc/inst/opcode : slot presented to decode
//   id_misalign                   : slot is an instruction-address-misaligned marker
// Optional: YSYX_22040931_IFU_MISALIGN_EN turns a misaligned redirect into a
// marker slot instead of silently aligning the target.
module ysyx_22040931_ifu
    import ysyx_22040931_ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_inst,
    output logic [6:0]      id_opcode,
    output logic            id_misalign
);

    if_state_e       state_q, state_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [31:0]     id_inst_q, id_inst_d;
    logic            id_mis_q, id_mis_d;
    logic [XLEN-1:0] pc;
    logic            req_fire;
    logic            pc_inc;
    logic            mis_redir;
    logic            outstanding;

`ifdef YSYX_22040931_IFU_MISALIGN_EN
    assign mis_redir = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign mis_redir = 1'b0;
`endif

    // drop_q set in REQ means a killed request is still in flight; hold off the
    // next request so at most one is ever outstanding.
    assign imem_req_valid = !rst && (state_q == IfReq) && !drop_q;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A marker slot does not advance the PC; execute redirects after trapping.
    assign pc_inc = (state_q == IfHold) && id_ready && !id_mis_q;

    // Whether a memory response is still owed after this cycle.
    assign outstanding = req_fire
                       || ((state_q == IfWait) && !imem_rsp_valid)
                       || (drop_q && !imem_rsp_valid);

    ysyx_22040931_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (redirect_valid),
        .load_pc_i (redirect_pc),
        .inc_i     (pc_inc),
        .pc_o      (pc)
    );

    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        id_mis_d  = id_mis_q;
        unique case (state_q)
            IfReq: begin
                if (req_fire) begin
                    state_d = IfWait;
                    // Accepted with the old address: its data must be thrown away.
                    if (redirect_valid) drop_d = 1'b1;
                end else if (drop_q && imem_rsp_valid) begin
                    drop_d = 1'b0;
                end
            end
            IfWait: begin
                if (imem_rsp_valid) begin
                    state_d = IfReq;
                    drop_d  = 1'b0;
                    if (!drop_q && !redirect_valid) begin
                        state_d   = IfHold;
                        id_pc_d   = pc;
                        id_inst_d = imem_rsp_data;
                        id_mis_d  = 1'b0;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            IfHold: begin
                if (drop_q && imem_rsp_valid) drop_d = 1'b0;
                if (id_ready || redirect_valid) begin
                    state_d  = IfReq;
                    id_mis_d = 1'b0;
                end
            end
            default: state_d = IfReq;
        endcase
        if (mis_redir) begin
            state_d   = IfHold;
            id_pc_d   = redirect_pc;
            id_inst_d = NOP_INST;
            id_mis_d  = 1'b1;
            drop_d    = outstanding;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IfReq;
            drop_q    <= 1'b0;
            id_pc_q   <= '0;
            id_inst_q <= '0;
            id_mis_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
            id_mis_q  <= id_mis_d;
        end
    end

    assign id_valid    = (state_q == IfHold);
    assign id_pc       = id_pc_q;
    assign id_inst     = id_inst_q;
    assign id_opcode   = id_inst_q[6:0];
    assign id_misalign = id_mis_q;

endmodule

// File: tb/tb_ysyx_22040931_ifu.sv
// Directed, table-driven bench for ysyx_22040931_ifu. Each row is one clock
// cycle: inputs driven after the falling edge, outputs compared 1 time unit
// later (before the next rising edge).
module tb_ysyx_22040931_ifu;

    localparam logic [63:0] A    = 64'h0000_0000_8000_0000;
    localparam logic [63:0] TOP  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] D0   = 32'h0000_0297;
    localparam logic [31:0] D1   = 32'h0010_0093;
    localparam logic [31:0] D2   = 32'h0020_8113;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic [6:0]  id_opcode;
    logic        id_misalign;

    ysyx_22040931_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_opcode      (id_opcode),
        .id_misalign    (id_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        rd_v;
        logic [63:0] rd_pc;
        logic        id_rdy;
        logic        e_req_v;
        logic [63:0] e_addr;
        logic        e_id_v;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic dv, input logic [63:0] dpc, input logic ir,
                       input logic eqv, input logic [63:0] ea, input logic eiv,
                       input logic [63:0] ep, input logic [31:0] ei);
        vec_t v;
        v.rst = r;     v.rdy = rdy;  v.rsp_v = rv;  v.rsp_d = rd;
        v.rd_v = dv;   v.rd_pc = dpc; v.id_rdy = ir;
        v.e_req_v = eqv; v.e_addr = ea; v.e_id_v = eiv; v.e_pc = ep; v.e_inst = ei;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic dv, input logic [63:0] dpc, input logic ir);
        rst = r; imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
        redirect_valid = dv; redirect_pc = dpc; id_ready = ir;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic        found;
        logic [31:0] inst_exp;
        logic [63:0] misal_pc;

        drive(1, 0, 0, 0, 0, 0, 0);

        // Reset state
        add(1, 0, 0, 0,   0, 0, 0,          0, A, 0, 0, 0);
        // Three sequential fetches, rsp one cycle after acceptance
        add(0, 1, 0, 0,   0, 0, 0,          1, A, 0, 0, 0);
        add(0, 0, 1, D0,  0, 0, 0,          0, A, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 1,          0, A, 1, A, D0);
        add(0, 1, 0, 0,   0, 0, 0,          1, A + 4, 0, 0, 0);
        add(0, 0, 1, D1,  0, 0, 0,          0, A + 4, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 1,          0, A + 4, 1, A + 4, D1);
        add(0, 1, 0, 0,   0, 0, 0,          1, A + 8, 0, 0, 0);
        add(0, 0, 1, D2,  0, 0, 0,          0, A + 8, 0, 0, 0);
        // Decode stalls 5 cycles: slot stable, no new request although memory ready
        for (int k = 0; k < 5; k++) add(0, 1, 0, 0, 0, 0, 0, 0, A + 8, 1, A + 8, D2);
        add(0, 1, 0, 0,   0, 0, 1,          0, A + 8, 1, A + 8, D2);
        add(0, 1, 0, 0,   0, 0, 0,          1, A + 12, 0, 0, 0);
        // Redirect in WAIT, response 3 cycles later is discarded
        add(0, 0, 0, 0,   1, A + 64'h100, 0, 0, A + 12, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0,          0, A + 64'h100, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0,          0, A + 64'h100, 0, 0, 0);
        add(0, 0, 1, D0,  0, 0, 0,          0, A + 64'h100, 0, 0, 0);
        // Memory not ready 4 cycles, redirect in the 2nd
        add(0, 0, 0, 0,   0, 0, 0,          1, A + 64'h100, 0, 0, 0);
        add(0, 0, 0, 0,   1, A + 64'h200, 0, 1, A + 64'h100, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0,          1, A + 64'h200, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0,          1, A + 64'h200, 0, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0,          1, A + 64'h200, 0, 0, 0);
        add(0, 0, 1, D1,  0, 0, 0,          0, A + 64'h200, 0, 0, 0);
        // Redirect in HOLD together with id_ready: delivered once, then redirect target
        add(0, 0, 0, 0,   1, A + 64'h300, 1, 0, A + 64'h200, 1, A + 64'h200, D1);
        add(0, 0, 0, 0,   0, 0, 0,          1, A + 64'h300, 0, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0,          1, A + 64'h300, 0, 0, 0);
        add(0, 0, 1, D2,  0, 0, 0,          0, A + 64'h300, 0, 0, 0);
        // Redirect in HOLD without id_ready kills the slot
        add(0, 0, 0, 0,   1, A + 64'h400, 0, 0, A + 64'h300, 1, A + 64'h300, D2);
        // Redirect in REQ while accepted: old-address data is dropped
        add(0, 1, 0, 0,   1, A + 64'h500, 0, 1, A + 64'h400, 0, 0, 0);
        add(0, 0, 1, D0,  0, 0, 0,          0, A + 64'h500, 0, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0,          1, A + 64'h500, 0, 0, 0);
        // Redirect in WAIT with rsp the same cycle
        add(0, 0, 1, D0,  1, A + 64'h600, 0, 0, A + 64'h500, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0,          1, A + 64'h600, 0, 0, 0);
`ifdef YSYX_22040931_IFU_MISALIGN_EN
        misal_pc = A + 64'h700;
`else
        misal_pc = A + 64'h702;
`endif
        // Unaligned target is word-aligned in the default build
        add(0, 0, 0, 0,   1, misal_pc, 0,   1, A + 64'h600, 0, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0,          1, A + 64'h700, 0, 0, 0);
        add(0, 0, 1, JAL, 0, 0, 0,          0, A + 64'h700, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0,          0, A + 64'h700, 1, A + 64'h700, JAL);
        // PC wrap at the top of the address space
        add(0, 0, 0, 0,   1, TOP, 1,        0, A + 64'h700, 1, A + 64'h700, JAL);
        add(0, 1, 0, 0,   0, 0, 0,          1, TOP, 0, 0, 0);
        add(0, 0, 1, NOP, 0, 0, 0,          0, TOP, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 1,          0, TOP, 1, TOP, NOP);
        add(0, 0, 0, 0,   0, 0, 0,          1, 64'h0, 0, 0, 0);
        // Reset mid-WAIT (redirect ignored), stray response afterwards ignored
        add(0, 1, 0, 0,   0, 0, 0,          1, 64'h0, 0, 0, 0);
        add(1, 0, 0, 0,   1, A + 64'h800, 0, 0, 64'h0, 0, 0, 0);
        add(0, 0, 1, D1,  0, 0, 0,          1, A, 0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0,          1, A, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].rsp_v, tbl[i].rsp_d,
                  tbl[i].rd_v, tbl[i].rd_pc, tbl[i].id_rdy);
            #1;
            n_vec++;
            chk($sformatf("row%0d req_valid", i), 64'(imem_req_valid), 64'(tbl[i].e_req_v));
            chk($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("row%0d id_valid", i), 64'(id_valid), 64'(tbl[i].e_id_v));
            chk($sformatf("row%0d id_misalign", i), 64'(id_misalign), 64'h0);
            if (tbl[i].e_id_v) begin
                inst_exp = tbl[i].e_inst;
                chk($sformatf("row%0d id_pc", i), id_pc, tbl[i].e_pc);
                chk($sformatf("row%0d id_inst", i), 64'(id_inst), 64'(inst_exp));
                chk($sformatf("row%0d id_opcode", i), 64'(id_opcode), 64'(inst_exp[6:0]));
            end
            if (i == 0) begin
                chk("reset id_pc", id_pc, 64'h0);
                chk("reset id_inst", 64'(id_inst), 64'h0);
            end
            @(negedge clk);
        end

        // Two-cycle memory latency, wait for the slot with a cycle budget
        drive(0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, D2, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            #1;
            if (id_valid) found = 1'b1;
            else @(negedge clk);
        end
        n_vec++;
        chk("latency id_valid within budget", 64'(found), 64'h1);
        chk("latency id_pc", id_pc, A);
        chk("latency id_inst", 64'(id_inst), 64'(D2));
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        #1;
        n_vec++;
        chk("after accept req_addr", imem_req_addr, A + 4);
        chk("after accept req_valid", 64'(imem_req_valid), 64'h1);

        // Misaligned redirect
        @(negedge clk);
        drive(0, 0, 0, 0, 1, A + 64'h102, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_vec++;
`ifdef YSYX_22040931_IFU_MISALIGN_EN
        chk("misalign req_valid", 64'(imem_req_valid), 64'h0);
        chk("misalign id_valid", 64'(id_valid), 64'h1);
        chk("misalign id_misalign", 64'(id_misalign), 64'h1);
        chk("misalign id_pc", id_pc, A + 64'h102);
        chk("misalign id_inst", 64'(id_inst), 64'(NOP));
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        #1;
        n_vec++;
        chk("misalign after accept id_valid", 64'(id_valid), 64'h0);
        chk("misalign after accept req_addr", imem_req_addr, A + 64'h102);
`else
        chk("misalign req_valid", 64'(imem_req_valid), 64'h1);
        chk("misalign req_addr aligned", imem_req_addr, A + 64'h100);
        chk("misalign id_valid", 64'(id_valid), 64'h0);
        chk("misalign id_misalign", 64'(id_misalign), 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040931_ifu.md
Name: ysyx_22040931_ifu

Overview:
- Instruction fetch stage of the npc RV64 core; sits directly upstream of decode (Utype/Itype/... decoders).
- Owns the PC and issues one 32-bit fetch at a time to instruction memory over a valid/ready request and valid response.
- Presents {pc, inst, opcode} to decode over a valid/ready handshake.
- Accepts redirects from execute (branch/jump/trap); a redirect kills any fetch that decode has not yet accepted.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h8000_0000, PC value loaded by reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  fetch address, equal to the current PC.
- imem_rsp_valid  in  1  fetch data valid; arrives at least 1 cycle after acceptance.
- imem_rsp_data  in  32  fetched instruction.
- redirect_valid  in  1  PC redirect request.
- redirect_pc  in  XLEN  redirect target.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts the instruction.
- id_pc  out  XLEN  PC of the presented instruction.
- id_inst  out  32  presented instruction.
- id_opcode  out  7  id_inst[6:0], for the opcode-indexed decoders.
- id_misalign  out  1  presented slot is an instruction-address-misaligned marker (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge): pc=RESET_PC, state=REQ, drop=0. All outputs 0 except imem_req_addr=RESET_PC. imem_req_valid goes 1 in the first cycle after reset deasserts.
- REQ state:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready, go to WAIT.
- WAIT state:
  - imem_req_valid=0.
  - On imem_rsp_valid with drop=0: latch id_inst=imem_rsp_data, id_pc=pc; go to HOLD.
  - On imem_rsp_valid with drop=1: discard the data, clear drop, go to REQ.
- HOLD state:
  - id_valid=1; outputs stay stable until accepted.
  - On id_ready: pc=pc+4, go to REQ. No back-to-back fetch, so issue-to-issue spacing is at least 3 cycles.
- Redirect takes priority over normal sequencing:
  - REQ: pc=redirect_pc, stay in REQ. If imem_req_ready is also high that cycle, the request is accepted with the old address, so set drop=1 and go to WAIT.
  - WAIT: pc=redirect_pc, drop=1. If imem_rsp_valid is also high that cycle, discard the data and go straight to REQ with drop=0.
  - HOLD without id_ready: kill the slot (id_valid=0 next cycle), pc=redirect_pc, go to REQ.
  - HOLD with id_ready in the same cycle: the handshake completes (the instruction is delivered), then pc=redirect_pc instead of pc+4, go to REQ.
- redirect_valid while rst=1 is ignored.
- PC arithmetic is modulo 2^XLEN; pc+4 from 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
- id_valid never drops without a handshake, a redirect or reset.
- At most one request is ever outstanding.
- Reset mid-WAIT: a later stray imem_rsp_valid arriving in REQ is ignored.
- imem_rsp_valid in REQ or HOLD is ignored.

Optional Feature:
- Macro: YSYX_22040931_IFU_MISALIGN_EN.
- Defined:
  - A redirect_pc with [1:0]!=0 issues no memory request.
  - The next cycle enters HOLD with id_valid=1, id_pc=redirect_pc, id_inst=32'h0000_0013 (nop), id_misalign=1.
  - After id_ready: go to REQ, pc unchanged (execute traps and redirects).
- Not defined:
  - pc loads {redirect_pc[XLEN-1:2],2'b00}.
  - id_misalign is tied 0.

Decomposition:
- Shared defines.v gains:
  - FSM state encodings ysyx_22040931_IF_REQ/WAIT/HOLD (2 bits).
  - Reset PC constant.
  - NOP encoding.
- One natural sub-module: ysyx_22040931_pc_reg, holding the PC register with reset load, +4 increment, redirect mux and alignment handling.
- The FSM and output slot stay in the top module.

Test Plan:
- Reset release, memory always ready, rsp 1 cycle after acceptance, id_ready=1 → fetches at 0x8000_0000, 0x8000_0004, 0x8000_0008; id_opcode matches rsp_data[6:0] (e.g. 0x00000297 → 7'h17).
- id_ready held 0 for 5 cycles in HOLD → id_valid, id_pc and id_inst stable; no imem_req_valid; after id_ready, next request at pc+4.
- Redirect to 0x8000_0100 during WAIT, rsp arrives 3 cycles later → data discarded, id_valid stays 0, next request at 0x8000_0100.
- Redirect in HOLD with id_ready=1 in the same cycle → instruction delivered once; next request at redirect_pc, not pc+4.
- imem_req_ready=0 for 4 cycles with a redirect in the 2nd cycle → imem_req_addr switches to the new PC; the first accepted request carries the new PC.
- With YSYX_22040931_IFU_MISALIGN_EN defined, redirect to 0x8000_0102 → no memory request; id_valid=1, id_misalign=1, id_inst=0x00000013. Without the macro → request at 0x8000_0100.
